uart_rx_stream: RTL and testbench

Parametrised UART receive channel that succeeds the fixed 8N1 receiver top. It oversamples the serial line and supports configurable data width and parity. Received bytes are buffered in a FIFO and handed out over a valid/ready stream. It also keeps a synchronously clearable received-byte counter and sticky error flags. The block sits between the board RS-232 RXD pin and the memory-write path (boot loader / data loader).

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_sync_fifo.sv | 55 +++++
 rtl/uart_rx_stream.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx_stream.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receive FSM encoding, baud divider.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } rx_state_e;

  // 16x oversample divider, rounded to nearest, never below 1
  function automatic int calc_div(input longint clk_hz, input longint baud);
    longint d;
    d = (clk_hz + 8 * baud) / (16 * baud);
    return (d < 1) ? 1 : int'(d);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through FIFO. A push into a full FIFO is taken when a pop
// happens in the same cycle; a pop of an empty FIFO is ignored.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_empty   = (r_level == '0);
  assign o_full    = (r_level == (AW+1)'(DEPTH));
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_level   = r_level;

  // storage write; contents are don't-care while not counted in r_level
  always_ff @(posedge I_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  // pointers and occupancy
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_stream.sv
// Oversampling UART receiver with configurable width/parity, FWFT output
// FIFO on a valid/ready stream, byte counter and sticky error flags.
module uart_rx_stream
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 32
) (
  input  logic                         I_clk,
  input  logic                         I_rst_n,
  input  logic                         I_rxd,
  input  logic                         I_rx_ready,
  input  logic                         I_cnt_clr,
  input  logic                         I_err_clr,
  output logic [DATA_BITS-1:0]         O_rx_data,
  output logic                         O_rx_valid,
  output logic                         O_rx_done,
  output logic                         O_frame_err,
  output logic                         O_parity_err,
  output logic                         O_overrun,
  output logic [$clog2(FIFO_DEPTH):0]  O_fifo_level,
  output logic [CNT_W-1:0]             O_byte_count
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BC_W  = $clog2(DATA_BITS);

  rx_state_e            r_state, w_state_nxt;
  logic [1:0]           r_sync;
  logic                 r_rxd_q;
  logic [DIV_W-1:0]     r_div;
  logic [3:0]           r_tick;
  logic                 r_s7, r_s8;
  logic [DATA_BITS-1:0] r_shift;
  logic [BC_W-1:0]      r_bit_cnt;
  logic                 r_par_bit;
  logic                 r_done;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_frame_err, r_parity_err, r_overrun;

  logic w_rxd, w_fall, w_tick, w_at7, w_at8, w_at9, w_at15, w_maj;
  logic w_xor, w_par_bad, w_push, w_frame_set, w_par_set;
  logic w_full, w_empty, w_accept, w_ovr_set;

  assign w_rxd  = r_sync[1];
  assign w_fall = r_rxd_q & ~w_rxd;
  assign w_tick = (r_state != ST_IDLE) && (r_div == DIV_W'(DIV - 1));
  assign w_at7  = w_tick && (r_tick == 4'd7);
  assign w_at8  = w_tick && (r_tick == 4'd8);
  assign w_at9  = w_tick && (r_tick == 4'd9);
  assign w_at15 = w_tick && (r_tick == 4'd15);
  assign w_maj  = (r_s7 & r_s8) | (r_s7 & w_rxd) | (r_s8 & w_rxd);

  assign w_xor     = (^r_shift) ^ r_par_bit;
  assign w_par_bad = (PARITY == PAR_ODD)  ? ~w_xor :
                     (PARITY == PAR_EVEN) ?  w_xor : 1'b0;

  // 2-FF synchroniser plus one delay stage for falling-edge detection
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_sync  <= 2'b11;
      r_rxd_q <= 1'b1;
    end else begin
      r_sync  <= {r_sync[0], I_rxd};
      r_rxd_q <= r_sync[1];
    end
  end

  // oversample prescaler and 0..15 tick counter, both parked at 0 in IDLE
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_div  <= '0;
      r_tick <= '0;
    end else if (r_state == ST_IDLE || w_state_nxt == ST_IDLE) begin
      r_div  <= '0;
      r_tick <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) r_tick <= r_tick + 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next state; START waits out the rest of the start bit before DATA
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_fall) w_state_nxt = ST_START;
      ST_START: begin
        if (w_at8 && w_rxd) w_state_nxt = ST_IDLE;
        else if (w_at15)    w_state_nxt = ST_DATA;
      end
      ST_DATA:  if (w_at15 && r_bit_cnt == BC_W'(DATA_BITS - 1))
                  w_state_nxt = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
      ST_PAR:   if (w_at15) w_state_nxt = ST_STOP;
      ST_STOP:  if (w_at9)  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: frame outcome decided at the stop-bit majority sample
  always_comb begin
    w_push      = 1'b0;
    w_frame_set = 1'b0;
    w_par_set   = 1'b0;
    if (r_state == ST_STOP && w_at9) begin
      w_frame_set = ~w_maj;
      w_par_set   = w_maj & w_par_bad;
      w_push      = w_maj & ~w_par_bad;
    end
  end

  // mid-bit samples, LSB-first shift register, bit count and parity bit
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_s7      <= 1'b1;
      r_s8      <= 1'b1;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_par_bit <= 1'b0;
    end else begin
      if (w_at7) r_s7 <= w_rxd;
      if (w_at8) r_s8 <= w_rxd;
      if (r_state == ST_IDLE) r_bit_cnt <= '0;
      if (r_state == ST_DATA && w_at9)  r_shift   <= {w_maj, r_shift[DATA_BITS-1:1]};
      if (r_state == ST_DATA && w_at15) r_bit_cnt <= r_bit_cnt + 1'b1;
      if (r_state == ST_PAR && w_at9)   r_par_bit <= w_maj;
    end
  end

  // a full FIFO still takes the byte if the consumer pops in the same cycle
  assign w_accept  = w_push & (~w_full | I_rx_ready);
  assign w_ovr_set = w_push & w_full & ~I_rx_ready;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .I_clk   (I_clk),
    .I_rst_n (I_rst_n),
    .i_push  (w_push),
    .i_data  (r_shift),
    .i_pop   (I_rx_ready),
    .o_data  (O_rx_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (O_fifo_level)
  );

  // done pulse, byte counter (clear beats increment), sticky flags (set beats clear)
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_done       <= 1'b0;
      r_cnt        <= '0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_done <= w_accept;
      if (I_cnt_clr)     r_cnt <= '0;
      else if (w_accept) r_cnt <= r_cnt + 1'b1;
      if (w_frame_set)    r_frame_err  <= 1'b1;
      else if (I_err_clr) r_frame_err  <= 1'b0;
      if (w_par_set)      r_parity_err <= 1'b1;
      else if (I_err_clr) r_parity_err <= 1'b0;
      if (w_ovr_set)      r_overrun    <= 1'b1;
      else if (I_err_clr) r_overrun    <= 1'b0;
    end
  end

  assign O_rx_valid   = ~w_empty;
  assign O_rx_done    = r_done;
  assign O_byte_count = r_cnt;
  assign O_frame_err  = r_frame_err;
  assign O_parity_err = r_parity_err;
  assign O_overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_stream.sv
// Directed bench: instance A is 8N1 with a 32-bit counter, instance B is
// 8E1 with a 4-bit counter. 32 clocks per bit (DIV=2).
module tb_uart_rx_stream;

  logic I_clk = 1'b0;
  logic I_rst_n = 1'b0;
  always #5 I_clk = ~I_clk;

  logic [1:0] rxd  = 2'b11;
  logic [1:0] rdy  = 2'b00;
  logic [1:0] cclr = 2'b00;
  logic [1:0] eclr = 2'b00;
  logic [7:0] data_a, data_b;
  logic [1:0] valid, done, ferr, perr, ovr;
  logic [4:0] lvl_a, lvl_b;
  logic [31:0] cnt_a;
  logic [3:0]  cnt_b;

  int checks = 0;
  int failures = 0;
  int done_cnt [2] = '{0, 0};
  logic [7:0] q_a [$];
  logic [7:0] q_b [$];

  uart_rx_stream #(.CLK_HZ(100_000_000), .BAUD(3_125_000), .DATA_BITS(8),
                   .PARITY(0), .FIFO_DEPTH(16), .CNT_W(32)) dut_a (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_rxd(rxd[0]), .I_rx_ready(rdy[0]),
    .I_cnt_clr(cclr[0]), .I_err_clr(eclr[0]), .O_rx_data(data_a),
    .O_rx_valid(valid[0]), .O_rx_done(done[0]), .O_frame_err(ferr[0]),
    .O_parity_err(perr[0]), .O_overrun(ovr[0]), .O_fifo_level(lvl_a),
    .O_byte_count(cnt_a));

  uart_rx_stream #(.CLK_HZ(100_000_000), .BAUD(3_125_000), .DATA_BITS(8),
                   .PARITY(2), .FIFO_DEPTH(16), .CNT_W(4)) dut_b (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_rxd(rxd[1]), .I_rx_ready(rdy[1]),
    .I_cnt_clr(cclr[1]), .I_err_clr(eclr[1]), .O_rx_data(data_b),
    .O_rx_valid(valid[1]), .O_rx_done(done[1]), .O_frame_err(ferr[1]),
    .O_parity_err(perr[1]), .O_overrun(ovr[1]), .O_fifo_level(lvl_b),
    .O_byte_count(cnt_b));

  // observe done pulses and stream handshakes away from the clock edge
  always @(negedge I_clk) begin
    if (done[0]) done_cnt[0]++;
    if (done[1]) done_cnt[1]++;
    if (valid[0] && rdy[0]) q_a.push_back(data_a);
    if (valid[1] && rdy[1]) q_b.push_back(data_b);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge I_clk);
    #1;
  endtask

  // one frame: start, 8 data LSB first, optional parity, stop, one idle bit.
  // clr_at_push holds I_cnt_clr from the stop bit until the push edge.
  task automatic send(input int s, input logic [7:0] d, input bit pe,
                      input bit pv, input bit sv, input bit clr_at_push);
    rxd[s] = 1'b0; cyc(32);
    for (int i = 0; i < 8; i++) begin rxd[s] = d[i]; cyc(32); end
    if (pe) begin rxd[s] = pv; cyc(32); end
    rxd[s] = sv;
    if (clr_at_push) cclr[s] = 1'b1;
    for (int i = 0; i < 32; i++) begin
      cyc(1);
      if (cclr[s] && done[s]) cclr[s] = 1'b0;
    end
    if (clr_at_push) cclr[s] = 1'b0;
    rxd[s] = 1'b1; cyc(32);
  endtask

  task automatic sa(input logic [7:0] d);
    send(0, d, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic sb(input logic [7:0] d);
    send(1, d, 1'b1, ^d, 1'b1, 1'b0);
  endtask

  task automatic err_clear(input int s);
    eclr[s] = 1'b1; cyc(1); eclr[s] = 1'b0; cyc(1);
  endtask

  logic [7:0] exp3 [3] = '{8'h55, 8'hA3, 8'h00};

  initial begin
    // reset state
    cyc(4);
    chk("rst_data", data_a, 0);   chk("rst_valid", valid[0], 0);
    chk("rst_done", done[0], 0);  chk("rst_ferr", ferr[0], 0);
    chk("rst_perr", perr[0], 0);  chk("rst_ovr", ovr[0], 0);
    chk("rst_lvl", lvl_a, 0);     chk("rst_cnt", cnt_a, 0);
    I_rst_n = 1'b1; cyc(4);

    // three 8N1 frames streamed out with ready high
    rdy = 2'b11;
    sa(8'h55); sa(8'hA3); sa(8'h00);
    chk("s1_done", done_cnt[0], 3);
    chk("s1_qlen", q_a.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < q_a.size()) chk("s1_data", q_a[i], exp3[i]);
    chk("s1_cnt", cnt_a, 3);
    chk("s1_flags", {ferr[0], perr[0], ovr[0]}, 0);
    chk("s1_lvl", lvl_a, 0);
    q_a.delete();

    // stop bit low: frame error, byte discarded; next frame still good
    send(0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fe_flag", ferr[0], 1);
    chk("fe_done", done_cnt[0], 3);
    chk("fe_qlen", q_a.size(), 0);
    chk("fe_cnt", cnt_a, 3);
    sa(8'h11);
    chk("fe_next_qlen", q_a.size(), 1);
    if (q_a.size() > 0) chk("fe_next_data", q_a[0], 8'h11);
    chk("fe_sticky", ferr[0], 1);
    err_clear(0);
    chk("fe_clr", ferr[0], 0);
    q_a.delete();

    // 16-clock glitch on the idle line is rejected at the start-bit sample
    rxd[0] = 1'b0; cyc(16); rxd[0] = 1'b1; cyc(64);
    chk("gl_done", done_cnt[0], 4);
    chk("gl_flags", {ferr[0], perr[0], ovr[0]}, 0);
    chk("gl_lvl", lvl_a, 0);
    chk("gl_cnt", cnt_a, 4);
    sa(8'h66);
    chk("gl_next_qlen", q_a.size(), 1);
    if (q_a.size() > 0) chk("gl_next_data", q_a[0], 8'h66);
    q_a.delete();

    // counter clear, then 17 frames into a stalled FIFO
    cclr[0] = 1'b1; cyc(1); cclr[0] = 1'b0; cyc(1);
    chk("cc_cnt", cnt_a, 0);
    rdy[0] = 1'b0;
    for (int i = 0; i < 17; i++) sa(8'h10 + 8'(i));
    chk("ov_lvl", lvl_a, 16);
    chk("ov_flag", ovr[0], 1);
    chk("ov_cnt", cnt_a, 16);
    chk("ov_done", done_cnt[0], 21);
    chk("ov_valid", valid[0], 1);
    chk("ov_head", data_a, 8'h10);
    rdy[0] = 1'b1;
    for (int i = 0; i < 200 && valid[0]; i++) cyc(1);
    chk("dr_valid", valid[0], 0);
    chk("dr_data", data_a, 0);
    chk("dr_lvl", lvl_a, 0);
    chk("dr_qlen", q_a.size(), 16);
    for (int i = 0; i < 16; i++)
      if (i < q_a.size()) chk("dr_order", q_a[i], 8'h10 + 8'(i));
    q_a.delete();

    // even parity: wrong parity bit discards, clear drops the flag
    send(1, 8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("pe_flag", perr[1], 1);
    chk("pe_cnt", cnt_b, 0);
    chk("pe_done", done_cnt[1], 0);
    chk("pe_lvl", lvl_b, 0);
    err_clear(1);
    chk("pe_clr", perr[1], 0);
    sb(8'h07);
    chk("pb_cnt", cnt_b, 1);
    if (q_b.size() > 0) chk("pb_data", q_b[0], 8'h07);
    for (int i = 0; i < 14; i++) sb(8'hE0 + 8'(i));
    chk("wr_cnt15", cnt_b, 15);
    sb(8'hC3);
    chk("wr_cnt0", cnt_b, 0);
    sb(8'h81);
    chk("wr_cnt1", cnt_b, 1);
    send(1, 8'h42, 1'b1, ^(8'h42), 1'b1, 1'b1);
    chk("cc_coinc", cnt_b, 0);
    chk("cc_done", done_cnt[1], 18);
    chk("pb_perr", perr[1], 0);

    // reset in the middle of the data bits
    rdy[0] = 1'b0;
    rxd[0] = 1'b0; cyc(32); rxd[0] = 1'b1; cyc(32); rxd[0] = 1'b0; cyc(16);
    I_rst_n = 1'b0; cyc(2);
    rxd[0] = 1'b1; cyc(3);
    I_rst_n = 1'b1; cyc(400);
    chk("mr_valid", valid[0], 0); chk("mr_data", data_a, 0);
    chk("mr_flags", {ferr[0], perr[0], ovr[0]}, 0);
    chk("mr_lvl", lvl_a, 0);      chk("mr_cnt", cnt_a, 0);
    chk("mr_done", done_cnt[0], 21);
    rdy[0] = 1'b1;
    sa(8'h5A);
    chk("mr_next_qlen", q_a.size(), 1);
    if (q_a.size() > 0) chk("mr_next_data", q_a[0], 8'h5A);
    chk("mr_next_cnt", cnt_a, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
